// File: rtl/test_pattern_gen.sv
// Deterministic stimulus source for the logIP channels: counter, walking-one,
// Galois LFSR or burst/gap patterns, stepped once per prescaler tick.
module test_pattern_gen #(
   parameter int               WIDTH     = 8,
   parameter int               DIV_W     = 16,
   parameter logic [WIDTH-1:0] SEED      = 8'hA5,
   parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
   parameter int               BURST_LEN = 16,
   parameter int               GAP_LEN   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [1:0]       mode_i,
   input  logic [DIV_W-1:0] div_i,
   output logic [WIDTH-1:0] chan_o,
   output logic             tick_o
);

   localparam logic [1:0] MODE_COUNT = 2'd0;
   localparam logic [1:0] MODE_WALK  = 2'd1;
   localparam logic [1:0] MODE_LFSR  = 2'd2;
   localparam logic [1:0] MODE_BURST = 2'd3;

   localparam logic [0:0] ST_BURST = 1'b0;
   localparam logic [0:0] ST_GAP   = 1'b1;

   // idx must hold the longer of the two phase lengths
   localparam int MAXLEN = (BURST_LEN > GAP_LEN) ? BURST_LEN : GAP_LEN;
   localparam int IDX_W  = $clog2(MAXLEN + 1);
   localparam logic [IDX_W-1:0] BURST_END = IDX_W'(BURST_LEN);
   localparam logic [IDX_W-1:0] GAP_END   = IDX_W'(GAP_LEN);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

   logic [DIV_W-1:0] cnt_q,  cnt_d;
   logic [WIDTH-1:0] chan_q, chan_d;
   logic             tick_q, tick_d;
   logic [1:0]       mode_q, mode_d;
   logic [0:0]       bst_q,  bst_d;
   logic [IDX_W-1:0] idx_q,  idx_d;
   logic             tick_cond;

   function automatic logic [WIDTH-1:0] next_walk(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], v[WIDTH-1]};
   endfunction

   function automatic logic [WIDTH-1:0] next_lfsr(input logic [WIDTH-1:0] v);
      return (v >> 1) ^ (v[0] ? TAPS : '0);
   endfunction

   // >= rather than == so that shrinking div_i below cnt ticks immediately
   assign tick_cond = en_i && (cnt_q >= div_i);

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      chan_d = chan_q;
      mode_d = mode_q;
      bst_d  = bst_q;
      idx_d  = idx_q;
      if (!en_i) begin
         cnt_d = '0;
      end else if (!tick_cond) begin
         cnt_d = cnt_q + DIV_W'(1);
      end else begin
         cnt_d  = '0;
         tick_d = 1'b1;
         if (mode_i != mode_q) begin
            mode_d = mode_i;
            case (mode_i)
               MODE_COUNT: chan_d = '0;
               MODE_WALK:  chan_d = WIDTH'(1);
               MODE_LFSR:  chan_d = SEED;
               default: begin
                  chan_d = WIDTH'(1);
                  bst_d  = ST_BURST;
                  idx_d  = IDX_ONE;
               end
            endcase
         end else begin
            case (mode_q)
               MODE_COUNT: chan_d = chan_q + WIDTH'(1);
               MODE_WALK:  chan_d = next_walk(chan_q);
               MODE_LFSR:  chan_d = next_lfsr(chan_q);
               MODE_BURST: begin
                  if (bst_q == ST_BURST) begin
                     if (idx_q < BURST_END) begin
                        idx_d  = idx_q + IDX_ONE;
                        chan_d = WIDTH'(idx_q + IDX_ONE);
                     end else begin
                        bst_d  = ST_GAP;
                        idx_d  = IDX_ONE;
                        chan_d = '0;
                     end
                  end else begin
                     if (idx_q < GAP_END) begin
                        idx_d  = idx_q + IDX_ONE;
                        chan_d = '0;
                     end else begin
                        bst_d  = ST_BURST;
                        idx_d  = IDX_ONE;
                        chan_d = WIDTH'(1);
                     end
                  end
               end
               default: chan_d = chan_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         chan_q <= '0;
         tick_q <= 1'b0;
         mode_q <= MODE_COUNT;
         bst_q  <= ST_BURST;
         idx_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         chan_q <= chan_d;
         tick_q <= tick_d;
         mode_q <= mode_d;
         bst_q  <= bst_d;
         idx_q  <= idx_d;
      end
   end

   assign chan_o = chan_q;
   assign tick_o = tick_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen with BURST_LEN=4, GAP_LEN=2 and the
// default 8-bit LFSR seed/taps; outputs are sampled on the falling edge.
module tb_test_pattern_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [1:0]  mode;
   logic [15:0] div;
   logic [7:0]  chan;
   logic        tick;

   int passed = 0;
   int total  = 0;

   test_pattern_gen #(
      .WIDTH(8), .DIV_W(16), .SEED(8'hA5), .TAPS(8'hB8),
      .BURST_LEN(4), .GAP_LEN(2)
   ) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode),
      .div_i(div), .chan_o(chan), .tick_o(tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step_chk(input string tag, input logic exp_tick, input logic [7:0] exp_chan);
      @(negedge clk);
      check({tag, "_tick"}, 32'(tick), 32'(exp_tick));
      check({tag, "_chan"}, 32'(chan), 32'(exp_chan));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] burst_exp [12];
      burst_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00,
                    8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00};
      rst = 1'b1; en = 1'b0; mode = 2'd0; div = 16'd0;

      // reset state
      @(negedge clk);
      check("rst_chan", 32'(chan), 32'h0);
      check("rst_tick", 32'(tick), 32'h0);

      // T1: counter every cycle, wraps at tick 256
      rst = 1'b0; en = 1'b1;
      for (int i = 1; i <= 256; i++) step_chk("t1", 1'b1, 8'(i));

      // T2: div 3 -> tick every 4th cycle, chan stable between
      div = 16'd3;
      for (int k = 1; k <= 3; k++) begin
         for (int j = 0; j < 3; j++) step_chk("t2_hold", 1'b0, 8'(k - 1));
         step_chk("t2_tick", 1'b1, 8'(k));
      end

      // T3: walking one
      mode = 2'd1; div = 16'd0;
      for (int i = 0; i < 9; i++) step_chk("t3", 1'b1, 8'h01 << (i % 8));

      // T4: LFSR
      mode = 2'd2;
      step_chk("t4_a", 1'b1, 8'hA5);
      step_chk("t4_b", 1'b1, 8'hEA);
      step_chk("t4_c", 1'b1, 8'h75);
      step_chk("t4_d", 1'b1, 8'h82);
      for (int j = 5; j <= 255; j++) begin
         @(negedge clk);
         total++;
         assert (chan !== 8'h00 && chan !== 8'hA5) passed++;
         else $error("FAIL t4_period: observed %0h at tick %0d expected not 00/A5", chan, j);
      end
      step_chk("t4_wrap", 1'b1, 8'hA5);

      // T5: burst 4 / gap 2
      mode = 2'd3;
      for (int i = 0; i < 12; i++) step_chk("t5", 1'b1, burst_exp[i]);

      // T6a: div cut 9 -> 1 at cnt=5
      mode = 2'd0;
      step_chk("t6_sw", 1'b1, 8'h00);
      div = 16'd9;
      for (int j = 0; j < 5; j++) step_chk("t6_cnt", 1'b0, 8'h00);
      div = 16'd1;
      step_chk("t6_cut", 1'b1, 8'h01);

      // T6b: en low mid-count freezes and clears the prescaler
      div = 16'd3;
      step_chk("t6_pre", 1'b0, 8'h01);
      step_chk("t6_pre", 1'b0, 8'h01);
      en = 1'b0;
      for (int j = 0; j < 3; j++) step_chk("t6_frz", 1'b0, 8'h01);
      en = 1'b1;
      for (int j = 0; j < 3; j++) step_chk("t6_run", 1'b0, 8'h01);
      step_chk("t6_resume", 1'b1, 8'h02);

      // T6c: async reset mid-burst
      mode = 2'd3; div = 16'd0;
      step_chk("t6_b", 1'b1, 8'h01);
      step_chk("t6_b", 1'b1, 8'h02);
      step_chk("t6_b", 1'b1, 8'h03);
      #2 rst = 1'b1;
      #1;
      check("t6_arst_chan", 32'(chan), 32'h0);
      check("t6_arst_tick", 32'(tick), 32'h0);
      step_chk("t6_held", 1'b0, 8'h00);
      rst = 1'b0;
      step_chk("t6_post", 1'b1, 8'h01);
      step_chk("t6_post", 1'b1, 8'h02);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
